// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target endpoint.
package spi_target_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int          DEF_DATA_W    = 8;
    // Wide enough for any practical frame width; the top slices it down.
    localparam logic [63:0] DEF_IDLE_FILL = '1;
    localparam int          SYNC_DEPTH    = 2;

endpackage

// File: rtl/spi_target_if.sv
// Parallel-side handshake of the SPI target: TX buffer load and RX word delivery.
interface spi_target_if
    import spi_target_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport master (
        output tx_data, tx_load,
        input  tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport slave (
        input  tx_data, tx_load,
        output tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

endinterface

// File: rtl/spi_target_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, plus a previous-value flop
// that turns level changes of the synchronized signal into rise/fall pulses.
module sync_edge
    import spi_target_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic CLK,
    input  logic nRST,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [DEPTH-1:0] sync_q;
    logic             prev_q;
    logic             level;

    // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge
    // value, so the chain really is DEPTH flops deep instead of collapsing to one.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
            prev_q <= sync_q[DEPTH-1];
        end
    end

    assign level = sync_q[DEPTH-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target.sv
// SPI target endpoint: oversamples sck/ss_n/mosi in the CLK domain, receives
// MSB-first words into rx_data and shifts the buffered TX word out on miso.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_FILL = DEF_IDLE_FILL[DATA_W-1:0]
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        polarity,
    input  logic        phase,
    input  logic        sck,
    input  logic        ss_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    spi_target_if.slave bus
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_DEPTH-1:0] mosi_sync;
    logic mosi_s;

    sync_edge u_sck_sync (.CLK(CLK), .nRST(nRST), .d(sck),  .rise(sck_rise), .fall(sck_fall));
    sync_edge u_ss_sync  (.CLK(CLK), .nRST(nRST), .d(ss_n), .rise(ss_rise),  .fall(ss_fall));

    // mosi only needs the level, delayed to line up with the sck edge pulses.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) mosi_sync <= '0;
        else       mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_DEPTH-1];

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = polarity ? sck_fall : sck_rise;
    assign trail_edge  = polarity ? sck_rise : sck_fall;
    assign sample_edge = phase ? trail_edge : lead_edge;
    assign shift_edge  = phase ? lead_edge  : trail_edge;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              reload;
    logic [DATA_W-1:0] next_word;
    logic [DATA_W-1:0] rx_word;

    assign next_word = tx_ready_q ? IDLE_FILL : tx_buf_q;
    assign rx_word   = {rx_shift_q, mosi_s};

    // NOTE: every signal gets its default before the case, so no path through
    // this block leaves one unassigned and no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        reload     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = ACTIVE;
                    cnt_d     = '0;
                    reload    = 1'b1;
                    miso_oe_d = 1'b1;
                    miso_d    = next_word[DATA_W-1];
                    // With CPHA=1 the first leading edge re-presents the MSB,
                    // so keep it in the register; with CPHA=0 it is already out.
                    tx_shift_d = phase ? next_word : {next_word[DATA_W-2:0], 1'b0};
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else if (sample_edge) begin
                    rx_shift_d = rx_word[DATA_W-2:0];
                    if (cnt_q == LAST_BIT) begin
                        cnt_d      = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        reload     = 1'b1;
                        tx_shift_d = next_word;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    miso_d     = tx_shift_q[DATA_W-1];
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        if (reload) begin
            if (tx_ready_q) underrun_d = 1'b1;
            else            tx_ready_d = 1'b1;
        end
        // A load in the same cycle as an underrun reload still fills the buffer.
        if (bus.tx_load && tx_ready_q) begin
            tx_buf_d   = bus.tx_data;
            tx_ready_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
        end
    end

    assign miso            = miso_q;
    assign miso_oe         = miso_oe_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: drives an SPI master with a 16-CLK half period
// and checks received words, miso contents, pulses and reset behaviour.
module tb_spi_target;

    localparam int HALF = 16;

    logic CLK = 1'b0;
    logic nRST, polarity, phase, sck, ss_n, mosi, miso, miso_oe;

    spi_target_if #(.DATA_W(8)) bus ();

    spi_target #(.DATA_W(8)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .polarity (polarity),
        .phase    (phase),
        .sck      (sck),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    int         rx_cnt  = 0;
    int         ur_cnt  = 0;
    logic [7:0] rx_last = '0;

    always @(negedge CLK) begin
        if (bus.rx_valid) begin
            rx_cnt  <= rx_cnt + 1;
            rx_last <= bus.rx_data;
        end
        if (bus.tx_underrun) ur_cnt <= ur_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_mode(input logic pol, input logic ph);
        polarity = pol;
        phase    = ph;
        sck      = pol;
        wait_clk(8);
    endtask

    task automatic pulse_load(input logic [7:0] val);
        bus.tx_data = val;
        bus.tx_load = 1'b1;
        wait_clk(1);
        bus.tx_load = 1'b0;
    endtask

    // One (possibly partial) master frame; sel_ur counts underrun pulses at select.
    task automatic frame(input logic [7:0] mo, input int nbits, input bit start, input bit stop,
                         input int load_bit, input logic [7:0] load_val,
                         output logic [7:0] mi, output int sel_ur);
        int u0;
        mi     = '0;
        sel_ur = 0;
        if (start) begin
            u0   = ur_cnt;
            ss_n = 1'b0;
            wait_clk(8);
            sel_ur = ur_cnt - u0;
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == load_bit) pulse_load(load_val);
            if (!phase) begin
                mosi = mo[7-i];
                wait_clk(HALF);
                sck = ~polarity;
                mi[7-i] = miso;
                wait_clk(HALF);
                sck = polarity;
            end else begin
                sck  = ~polarity;
                mosi = mo[7-i];
                wait_clk(HALF);
                sck = polarity;
                mi[7-i] = miso;
                wait_clk(HALF);
            end
        end
        if (stop) begin
            wait_clk(8);
            ss_n = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " miso"},        miso,            1'b0);
        check({tag, " miso_oe"},     miso_oe,         1'b0);
        check({tag, " tx_ready"},    bus.tx_ready,    1'b1);
        check({tag, " rx_data"},     bus.rx_data,     8'h00);
        check({tag, " rx_valid"},    bus.rx_valid,    1'b0);
        check({tag, " tx_underrun"}, bus.tx_underrun, 1'b0);
        check({tag, " busy"},        bus.busy,        1'b0);
    endtask

    initial begin
        logic [7:0] mi;
        int         sur;
        int         r0;

        nRST = 1'b0; polarity = 1'b0; phase = 1'b0; sck = 1'b0;
        ss_n = 1'b1; mosi = 1'b0;
        bus.tx_data = '0; bus.tx_load = 1'b0;
        wait_clk(4);
        check_reset_outputs("por");
        nRST = 1'b1;
        wait_clk(4);

        // CPOL=0 CPHA=0, preloaded 0x3C, master sends 0xA5
        pulse_load(8'h3C);
        check("t1 tx_ready after load", bus.tx_ready, 1'b0);
        r0 = rx_cnt;
        frame(8'hA5, 8, 1'b1, 1'b1, -1, 8'h00, mi, sur);
        check("t1 select underrun", sur, 0);
        check("t1 miso word", mi, 8'h3C);
        check("t1 rx_valid pulses", rx_cnt - r0, 1);
        check("t1 rx word", rx_last, 8'hA5);
        check("t1 rx_data held", bus.rx_data, 8'hA5);
        check("t1 busy after", bus.busy, 1'b0);
        check("t1 miso_oe after", miso_oe, 1'b0);
        check("t1 tx_ready after", bus.tx_ready, 1'b1);

        // CPOL=1 CPHA=1, back-to-back 0x5A, 0xC3; 0x81 loaded during frame 1
        set_mode(1'b1, 1'b1);
        r0 = rx_cnt;
        frame(8'h5A, 8, 1'b1, 1'b0, 3, 8'h81, mi, sur);
        check("t2 select underrun", sur, 1);
        check("t2 frame1 miso", mi, 8'hFF);
        check("t2 frame1 rx", rx_last, 8'h5A);
        check("t2 busy between", bus.busy, 1'b1);
        frame(8'hC3, 8, 1'b0, 1'b1, -1, 8'h00, mi, sur);
        check("t2 frame2 miso", mi, 8'h81);
        check("t2 frame2 rx", rx_last, 8'hC3);
        check("t2 rx_valid pulses", rx_cnt - r0, 2);

        // CPOL=0 CPHA=1, nothing buffered: underrun at select
        set_mode(1'b0, 1'b1);
        frame(8'h3C, 8, 1'b1, 1'b1, -1, 8'h00, mi, sur);
        check("t3 select underrun", sur, 1);
        check("t3 miso word", mi, 8'hFF);
        check("t3 rx word", bus.rx_data, 8'h3C);

        // CPOL=0 CPHA=0, abort after 5 bits, then full frame 0x0F
        set_mode(1'b0, 1'b0);
        r0 = rx_cnt;
        frame(8'hF0, 5, 1'b1, 1'b0, -1, 8'h00, mi, sur);
        check("t4 busy mid frame", bus.busy, 1'b1);
        wait_clk(8);
        ss_n = 1'b1;
        wait_clk(8);
        check("t4 busy after abort", bus.busy, 1'b0);
        check("t4 no rx_valid", rx_cnt - r0, 0);
        check("t4 rx_data kept", bus.rx_data, 8'h3C);
        frame(8'h0F, 8, 1'b1, 1'b1, -1, 8'h00, mi, sur);
        check("t4 next frame rx", bus.rx_data, 8'h0F);
        check("t4 next frame pulses", rx_cnt - r0, 1);

        // reset after 3 bits, ss_n still low through release
        frame(8'h66, 3, 1'b1, 1'b0, -1, 8'h00, mi, sur);
        nRST = 1'b0;
        #1;
        check_reset_outputs("t5 in reset");
        wait_clk(3);
        nRST = 1'b1;
        wait_clk(10);
        check("t5 no restart without ss_n edge", bus.busy, 1'b0);
        ss_n = 1'b1;
        wait_clk(8);
        r0 = rx_cnt;
        frame(8'h99, 8, 1'b1, 1'b1, -1, 8'h00, mi, sur);
        check("t5 rx after reset", bus.rx_data, 8'h99);
        check("t5 pulses after reset", rx_cnt - r0, 1);

        // CPOL=1 CPHA=0, second load while full is ignored
        set_mode(1'b1, 1'b0);
        pulse_load(8'h42);
        check("t6 tx_ready after load", bus.tx_ready, 1'b0);
        pulse_load(8'hE7);
        check("t6 tx_ready after ignored load", bus.tx_ready, 1'b0);
        frame(8'h55, 8, 1'b1, 1'b1, -1, 8'h00, mi, sur);
        check("t6 select underrun", sur, 0);
        check("t6 miso word", mi, 8'h42);
        check("t6 rx word", bus.rx_data, 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
